// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, bit positions, cause codes, CSR ops and FSM states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIP_MTIP_BIT     = 7;
    localparam int MIP_MEIP_BIT     = 11;

    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_SAVE = 2'd1,
        TRAP_JUMP = 2'd2,
        MRET_JUMP = 2'd3
    } trap_state_t;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap/mret sequencer for the single-cycle RV32 core.
// Interrupts are taken at instruction boundaries by stalling and redirecting the PC.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_retire,
    input  logic [XLEN-1:0] next_pc,
    input  logic            csr_wre,
    input  logic            csr_rde,
    input  logic            is_mret,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            ext_irq,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            stall,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] ADDR_MASK     = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'((1 << MSTATUS_MIE_BIT) | (1 << MSTATUS_MPIE_BIT));
    localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'((1 << MIE_MTIE_BIT) | (1 << MIE_MEIE_BIT));

    trap_state_t     state, state_nxt;
    logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q, mip_q;
    logic [XLEN-1:0] pc_hold_q;
    logic            ext_hold_q;
    logic [XLEN-1:0] csr_old, csr_new, mip_nxt, mstatus_trap, mstatus_mret;
    logic            pending, ext_pending, retire_idle, csr_we;
    logic            unused_funct3;

    function automatic logic [XLEN-1:0] csr_apply(input logic [1:0] op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wdata);
        case (op)
            CSR_OP_WRITE: return wdata;
            CSR_OP_SET:   return old | wdata;
            CSR_OP_CLEAR: return old & ~wdata;
            default:      return old;
        endcase
    endfunction

    assign unused_funct3 = csr_funct3[2];

    always_comb begin
        csr_old = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_old = mstatus_q;
            CSR_MIE:     csr_old = mie_q;
            CSR_MTVEC:   csr_old = mtvec_q;
            CSR_MEPC:    csr_old = mepc_q;
            CSR_MCAUSE:  csr_old = mcause_q;
            CSR_MIP:     csr_old = mip_q;
            default:     csr_old = '0;
        endcase
    end

    assign csr_rdata   = csr_rde ? csr_old : '0;
    assign csr_new     = csr_apply(csr_funct3[1:0], csr_old, csr_wdata);
    assign retire_idle = (state == IDLE) && instr_retire;
    assign csr_we      = retire_idle && csr_wre;

    assign ext_pending = mip_q[MIP_MEIP_BIT] && mie_q[MIE_MEIE_BIT];
    assign pending     = mstatus_q[MSTATUS_MIE_BIT] &&
                         (ext_pending || (mip_q[MIP_MTIP_BIT] && mie_q[MIE_MTIE_BIT]));

    always_comb begin
        mip_nxt               = '0;
        mip_nxt[MIP_MTIP_BIT] = timer_irq;
        mip_nxt[MIP_MEIP_BIT] = ext_irq;
    end

    always_comb begin
        mstatus_trap                   = mstatus_q;
        mstatus_trap[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
        mstatus_trap[MSTATUS_MIE_BIT]  = 1'b0;
        mstatus_mret                   = mstatus_q;
        mstatus_mret[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
        mstatus_mret[MSTATUS_MPIE_BIT] = 1'b1;
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        case (state)
            IDLE: begin
                if (instr_retire && is_mret) begin
                    state_nxt = MRET_JUMP;
                end else if (instr_retire && pending) begin
                    state_nxt = TRAP_SAVE;
                end
            end
            TRAP_SAVE: begin
                stall     = 1'b1;
                state_nxt = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                stall       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = {mtvec_q[XLEN-1:2], 2'b00};
                state_nxt   = IDLE;
            end
            MRET_JUMP: begin
                stall       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = mepc_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Architectural CSR state; trap and mret updates only occur outside IDLE,
    // so they never collide with an instruction's CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= '0;
            mie_q     <= '0;
            mtvec_q   <= MTVEC_RESET & ADDR_MASK;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mip_q     <= '0;
        end else begin
            mip_q <= mip_nxt;
            if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: mstatus_q <= csr_new & MSTATUS_WMASK;
                    CSR_MIE:     mie_q     <= csr_new & MIE_WMASK;
                    CSR_MTVEC:   mtvec_q   <= csr_new & ADDR_MASK;
                    CSR_MEPC:    mepc_q    <= csr_new & ADDR_MASK;
                    CSR_MCAUSE:  mcause_q  <= csr_new;
                    default: ;
                endcase
            end
            case (state)
                TRAP_SAVE: begin
                    mepc_q    <= pc_hold_q & ADDR_MASK;
                    mcause_q  <= ext_hold_q ? XLEN'(CAUSE_M_EXT) : XLEN'(CAUSE_M_TIMER);
                    mstatus_q <= mstatus_trap;
                end
                MRET_JUMP: mstatus_q <= mstatus_mret;
                default: ;
            endcase
        end
    end

    // Retire-cycle snapshot consumed by TRAP_SAVE; a later irq drop cannot cancel it.
    always_ff @(posedge clk) begin
        if (retire_idle) begin
            pc_hold_q  <= next_pc;
            ext_hold_q <= ext_pending;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed trap/mret scenarios plus a randomized phase,
// all checked against a cycle-level behavioural model of the CSR file.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst, instr_retire, csr_wre, csr_rde, is_mret, ext_irq, timer_irq;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] next_pc, csr_wdata, csr_rdata, redirect_pc;
    logic        stall, pc_redirect;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: CSR values plus "cycles left in current sequence"
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip, m_hold_pc;
    bit          m_hold_ext, m_is_trap;
    int          m_left;

    logic [11:0] addr_tab [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                  12'h342, 12'h344, 12'h7C0, 12'h301};

    always #5 clk = ~clk;

    csr_trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_retire (instr_retire),
        .next_pc      (next_pc),
        .csr_wre      (csr_wre),
        .csr_rde      (csr_rde),
        .is_mret      (is_mret),
        .csr_funct3   (csr_funct3),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .csr_rdata    (csr_rdata),
        .stall        (stall),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc)
    );

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
        m_mip = 0; m_left = 0; m_is_trap = 0; m_hold_pc = 0; m_hold_ext = 0;
    endtask

    task automatic model_edge();
        logic [31:0] old, nw, nxt_mip;
        bit pend, ext;
        nxt_mip = (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
        if (rst) begin
            model_reset();
            return;
        end
        if (m_left == 0) begin
            if (instr_retire) begin
                pend = m_mstatus[3] && ((m_mip & m_mie & 32'h880) != 0);
                ext  = (m_mip & m_mie & 32'h800) != 0;
                if (csr_wre && csr_funct3[1:0] != 2'b00) begin
                    old = m_read(csr_addr);
                    if (csr_funct3[1:0] == 2'b01)      nw = csr_wdata;
                    else if (csr_funct3[1:0] == 2'b10) nw = old | csr_wdata;
                    else                               nw = old & ~csr_wdata;
                    case (csr_addr)
                        12'h300: m_mstatus = nw & 32'h88;
                        12'h304: m_mie     = nw & 32'h880;
                        12'h305: m_mtvec   = nw & ~32'h3;
                        12'h341: m_mepc    = nw & ~32'h3;
                        12'h342: m_mcause  = nw;
                        default: ;
                    endcase
                end
                if (is_mret) begin
                    m_left = 1; m_is_trap = 0;
                end else if (pend) begin
                    m_left = 2; m_is_trap = 1; m_hold_pc = next_pc; m_hold_ext = ext;
                end
            end
        end else if (m_is_trap && m_left == 2) begin
            m_mepc    = m_hold_pc & ~32'h3;
            m_mcause  = m_hold_ext ? 32'h8000_000B : 32'h8000_0007;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_left    = 1;
        end else begin
            if (!m_is_trap) m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            m_left = 0;
        end
        m_mip = nxt_mip;
    endtask

    task automatic drive(input bit r, input bit w, input bit rd, input bit mr,
                         input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] npc);
        instr_retire = r; csr_wre = w; csr_rde = rd; is_mret = mr;
        csr_funct3 = f3; csr_addr = a; csr_wdata = wd; next_pc = npc;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // One cycle with all outputs compared against the model before the edge.
    task automatic step(input string tag);
        logic [31:0] exp_pc;
        @(negedge clk);
        exp_pc = (m_left == 1) ? (m_is_trap ? m_mtvec : m_mepc) : 32'h0;
        check({tag, ".stall"}, {31'b0, stall}, {31'b0, m_left > 0});
        check({tag, ".redir"}, {31'b0, pc_redirect}, {31'b0, m_left == 1});
        check({tag, ".rpc"}, redirect_pc, exp_pc);
        check({tag, ".rdata"}, csr_rdata, csr_rde ? m_read(csr_addr) : 32'h0);
        finish_cycle();
    endtask

    task automatic expect_out(input string tag, input bit s, input bit r, input logic [31:0] pc);
        @(negedge clk);
        check({tag, ".stall"}, {31'b0, stall}, {31'b0, s});
        check({tag, ".redir"}, {31'b0, pc_redirect}, {31'b0, r});
        check({tag, ".rpc"}, redirect_pc, pc);
        finish_cycle();
    endtask

    task automatic rd_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
        drive(0, 0, 1, 0, 3'b000, a, 32'h0, 32'h0);
        @(negedge clk);
        check(tag, csr_rdata, exp);
        finish_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        ext_irq = 1'b0; timer_irq = 1'b0;
        do_reset();

        rd_const("rst_mtvec", 12'h305, 32'h0000_0100);
        rd_const("rst_mstatus", 12'h300, 32'h0);
        rd_const("rst_mie", 12'h304, 32'h0);
        rd_const("rst_mepc", 12'h341, 32'h0);
        rd_const("rst_mcause", 12'h342, 32'h0);
        rd_const("rst_mip", 12'h344, 32'h0);
        rd_const("rst_unimpl", 12'h7C0, 32'h0);
        expect_out("rst_idle", 0, 0, 32'h0);

        // CSR writes; rdata shows the pre-write value in the write cycle
        drive(1, 1, 1, 0, 3'b001, 12'h304, 32'h800, $urandom);
        step("csrrw_mie");
        drive(1, 1, 1, 0, 3'b010, 12'h300, 32'h8, $urandom);
        step("csrrs_mstatus");
        rd_const("mie_wr", 12'h304, 32'h800);
        rd_const("mstatus_wr", 12'h300, 32'h8);
        drive(0, 1, 0, 0, 3'b001, 12'h342, 32'hDEAD_BEEF, 32'h0);
        step("wr_no_retire");
        rd_const("mcause_untouched", 12'h342, 32'h0);

        // External interrupt entry
        ext_irq = 1'b1;
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        step("irq_sync");
        rd_const("mip_ext", 12'h344, 32'h800);
        drive(1, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h40);
        expect_out("retire_irq", 0, 0, 32'h0);
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        expect_out("trap_save", 1, 0, 32'h0);
        expect_out("trap_jump", 1, 1, 32'h100);
        expect_out("trap_done", 0, 0, 32'h0);
        rd_const("trap_mepc", 12'h341, 32'h40);
        rd_const("trap_mcause", 12'h342, 32'h8000_000B);
        rd_const("trap_mstatus", 12'h300, 32'h80);

        // mret, then re-trap with ext_irq still high
        drive(1, 0, 0, 1, 3'b000, 12'h0, 32'h0, $urandom);
        expect_out("mret_retire", 0, 0, 32'h0);
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        expect_out("mret_jump", 1, 1, 32'h40);
        rd_const("mret_mstatus", 12'h300, 32'h88);
        drive(1, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0000_0200);
        step("retrap_retire");
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        step("retrap_save");
        step("retrap_jump");
        rd_const("retrap_mepc", 12'h341, 32'h200);

        // Both irqs pending and enabled: external wins
        timer_irq = 1'b1;
        drive(1, 1, 0, 0, 3'b010, 12'h304, 32'h80, $urandom);
        step("set_mtie");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 3'b000, 12'h0, 32'h0, $urandom);
            expect_out("mie0_notrap", 0, 0, 32'h0);
        end
        rd_const("mip_both", 12'h344, 32'h880);
        drive(1, 1, 0, 0, 3'b010, 12'h300, 32'h8, $urandom);
        step("set_mie_bit");
        drive(1, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h1234_5677);
        step("both_retire");
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        step("both_save");
        step("both_jump");
        rd_const("both_mcause", 12'h342, 32'h8000_000B);
        rd_const("both_mepc", 12'h341, 32'h1234_5674);

        // Timer only
        ext_irq = 1'b0;
        drive(1, 0, 0, 1, 3'b000, 12'h0, 32'h0, 32'h0);
        step("tmr_mret");
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        step("tmr_mret_jump");
        drive(1, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0000_0888);
        step("tmr_retire");
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        step("tmr_save");
        step("tmr_jump");
        rd_const("tmr_mcause", 12'h342, 32'h8000_0007);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            ext_irq   = ($urandom_range(0, 5) == 0);
            timer_irq = ($urandom_range(0, 5) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 9) == 0, 3'($urandom), addr_tab[$urandom_range(0, 7)],
                  $urandom, $urandom);
            step("rand");
        end

        // Reset in the middle of a trap sequence
        ext_irq = 1'b1; timer_irq = 1'b0;
        do_reset();
        drive(1, 1, 0, 0, 3'b010, 12'h304, 32'h800, $urandom);
        step("rst_setup_mie");
        drive(1, 1, 0, 0, 3'b010, 12'h300, 32'h8, $urandom);
        step("rst_setup_mstatus");
        drive(1, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h80);
        step("rst_retire");
        drive(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 32'h0);
        rst = 1'b1;
        expect_out("rst_in_save", 1, 0, 32'h0);
        rst = 1'b0;
        expect_out("after_rst", 0, 0, 32'h0);
        expect_out("after_rst2", 0, 0, 32'h0);
        rd_const("after_rst_mepc", 12'h341, 32'h0);
        rd_const("after_rst_mtvec", 12'h305, 32'h100);
        rd_const("after_rst_mstatus", 12'h300, 32'h0);
        rd_const("after_rst_mcause", 12'h342, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
